rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 data mux between four valid/ready requesters and one downstream consumer. It holds a registered grant select that drives the mux, bounds each grant to MAX_BURST beats, and rotates priority for fairness. It sits in front of any shared single-consumer resource.

---
 rtl/rr_mux_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four valid/ready requesters.
// Each grant is capped at MAX_BURST beats and ends with a one-cycle IDLE bubble before re-arbitration.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    input  logic [4*WIDTH-1:0]   req_data,
    output logic [3:0]           req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           grant_sel,
    output logic                 busy
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         grant_q;
    logic [1:0]         grant_d;
    logic [1:0]         ptr_q;
    logic [1:0]         ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [1:0]         pick;
    logic [1:0]         scan_idx;
    logic               sel_valid;
    logic [WIDTH-1:0]   sel_data;
    logic               xfer;

    // First requesting index found scanning ptr, ptr+1, ptr+2, ptr+3; the
    // descending loop lets the candidate closest to ptr overwrite the others.
    always_comb begin
        pick     = ptr_q;
        scan_idx = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req_valid[scan_idx]) begin
                pick = scan_idx;
            end
        end
    end

    // Shared data mux steered by the registered grant.
    always_comb begin
        sel_valid = req_valid[grant_q];
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == 2'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        busy      = (state_q == GRANT);
        out_valid = busy & sel_valid;
        out_data  = busy ? sel_data : '0;
        req_ready = '0;
        if (busy) begin
            req_ready[grant_q] = out_ready;
        end
        xfer      = out_valid & out_ready;
        grant_sel = grant_q;
    end

    // Next-state: a grant ends on burst exhaustion or when its requester drops valid.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = GRANT;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!sel_valid) begin
                    state_d = IDLE;
                    ptr_d   = grant_q + 2'd1;
                    cnt_d   = '0;
                end else if (xfer) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        ptr_d   = grant_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: expected beats are queued per test and
// checked by an independent monitor; cycle-exact state checks run inline.
module tb_rr_mux_arbiter;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic [1:0]         grant_sel;
    logic               busy;

    logic [7:0] dat [4];
    exp_t       q [$];
    int         n_cmp;
    int         n_mis;

    rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_sel (grant_sel),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_data[i*WIDTH +: WIDTH] = dat[i];
        end
    endtask

    // One clock: requesters that handshook advance their data (valid/ready source model).
    task automatic step();
        logic [3:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i] === 1'b1) begin
                dat[i] = dat[i] + 8'd1;
            end
        end
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.id   = id;
            e.data = first + 8'(i);
            q.push_back(e);
        end
    endtask

    // Monitor: every accepted output beat must match the head of the expected queue.
    initial begin
        exp_t e;
        logic [3:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_beat: got sel=%0d data=%0h expected none at %0t",
                             grant_sel, out_data, $time);
                end else begin
                    e = q.pop_front();
                    exp_rdy = 4'b0001 << e.id;
                    if (out_data !== e.data || grant_sel !== e.id || req_ready !== exp_rdy) begin
                        n_mis++;
                        $display("FAIL beat: got sel=%0d data=%0h rdy=%b expected sel=%0d data=%0h rdy=%b at %0t",
                                 grant_sel, out_data, req_ready, e.id, e.data, exp_rdy, $time);
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        dat[0] = 8'h00;
        dat[1] = 8'h10;
        dat[2] = 8'h20;
        dat[3] = 8'h30;
        drive();
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b0;

        // Reset held two cycles with all requesters valid
        steps(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_grant_sel", 32'(grant_sel), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_busy",      32'(busy),      32'd1);
        chk("post_rst_grant_sel", 32'(grant_sel), 32'd0);
        chk("post_rst_out_data",  32'(out_data),  32'h00);
        chk("post_rst_req_ready", 32'(req_ready), 32'd0);

        // Round robin, all saturated: order 0,1,2,3,0 with 4 beats each
        push(2'd0, 8'h00, 4);
        push(2'd1, 8'h10, 4);
        push(2'd2, 8'h20, 4);
        push(2'd3, 8'h30, 4);
        push(2'd0, 8'h04, 4);
        out_ready = 1'b1;
        steps(4);
        chk("rr_bubble_busy", 32'(busy), 32'd0);
        steps(20);
        chk("rr_end_busy", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        steps(2);
        chk("rr_drained", 32'(q.size()), 32'd0);

        // Single requester 2: 4-beat burst, bubble, re-grant, then early drop
        dat[2] = 8'hA5;
        drive();
        push(2'd2, 8'hA5, 6);
        req_valid = 4'b0100;
        step();
        chk("single_busy",      32'(busy),      32'd1);
        chk("single_grant_sel", 32'(grant_sel), 32'd2);
        chk("single_out_data",  32'(out_data),  32'hA5);
        chk("single_req_ready", 32'(req_ready), 32'b0100);
        steps(4);
        chk("single_bubble_busy", 32'(busy), 32'd0);
        step();
        chk("single_regrant_busy", 32'(busy),      32'd1);
        chk("single_regrant_sel",  32'(grant_sel), 32'd2);
        steps(2);
        req_valid = 4'b0000;
        step();
        chk("single_drop_busy", 32'(busy), 32'd0);
        step();

        // Backpressure on requester 1 after two beats
        dat[1] = 8'h50;
        drive();
        push(2'd1, 8'h50, 4);
        req_valid = 4'b0010;
        steps(3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_grant_sel", 32'(grant_sel), 32'd1);
            chk("bp_out_data",  32'(out_data),  32'h52);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_busy", 32'(busy), 32'd1);
        step();
        chk("bp_done_busy", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        step();

        // Early release of requester 3 with requester 1 pending
        dat[3] = 8'hC0;
        dat[1] = 8'hD0;
        drive();
        push(2'd3, 8'hC0, 2);
        push(2'd1, 8'hD0, 1);
        req_valid = 4'b1010;
        step();
        chk("early_grant_sel", 32'(grant_sel), 32'd3);
        steps(2);
        req_valid = 4'b0010;
        step();
        chk("early_release_busy", 32'(busy), 32'd0);
        step();
        chk("early_next_sel",  32'(grant_sel), 32'd1);
        chk("early_next_busy", 32'(busy),      32'd1);
        step();
        req_valid = 4'b0000;
        step();

        // Reset in the middle of a requester-2 burst
        dat[2] = 8'hE0;
        drive();
        push(2'd2, 8'hE0, 2);
        push(2'd0, 8'hF0, 1);
        req_valid = 4'b0100;
        step();
        chk("mid_grant_sel", 32'(grant_sel), 32'd2);
        steps(2);
        rst = 1'b1;
        req_valid = 4'b1111;
        dat[0] = 8'hF0;
        drive();
        step();
        chk("mid_rst_busy", 32'(busy),      32'd0);
        chk("mid_rst_sel",  32'(grant_sel), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_post_busy",     32'(busy),      32'd1);
        chk("mid_post_sel",      32'(grant_sel), 32'd0);
        chk("mid_post_out_data", 32'(out_data),  32'hF0);
        step();
        req_valid = 4'b0000;
        step();

        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            step();
        end
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
